mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port on-chip program/data RAM inside `top` between the CPU instruction-fetch port and the load/store port. It latches one request at a time, drives the RAM for one access cycle, and returns read data with a one-cycle acknowledge. Contention is resolved round-robin, so neither port can starve the other.

## Interface
- `ADDR_WIDTH`, 14: RAM word-address width.
- `DATA_WIDTH`, 32: word width. Byte enables are `DATA_WIDTH/8` bits wide.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_ack`.
- `i_addr`  in  ADDR_WIDTH  fetch word address.
- `i_ack`  out  1  one-cycle completion pulse for fetch.
- `i_rdata`  out  DATA_WIDTH  fetch read data; valid only while `i_ack`=1, else 0.
- `d_req`  in  1  data request; held high with the remaining `d_*` inputs stable until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_be`  in  DATA_WIDTH/8  byte enables for writes.
- `d_addr`  in  ADDR_WIDTH  data word address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_ack`  out  1  one-cycle completion pulse for data.
- `d_rdata`  out  DATA_WIDTH  read data; valid only while `d_ack`=1, else 0.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  DATA_WIDTH/8  RAM byte write enables.
- `mem_addr`  out  ADDR_WIDTH  RAM word address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after `mem_en`.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: RAM strobed.
  - RESP: ack issued.
- IDLE transitions:
  - If `i_req` or `d_req` is sampled high, select a winner.
  - Register the winner's address, wdata and write enables into `mem_*`.
  - Set `mem_en`=1 and go to ACCESS.
  - `mem_we` = `d_be` only if the data port wins with `d_we`=1; otherwise 0.
- ACCESS → RESP unconditionally. At that edge `mem_en` and `mem_we` are cleared.
- RESP → IDLE unconditionally.
  - The granted port's ack is 1 for exactly this cycle.
  - Its rdata = `mem_rdata`. The other port's ack and rdata stay 0.
- Arbitration:
  - A `last_grant` register records which port was granted last; it resets to DATA.
  - If only one port requests, that port wins.
  - If both request in IDLE, the port not recorded in `last_grant` wins, and `last_grant` updates at the grant.
- Writes also complete with an ack in RESP. `d_rdata` then carries the RAM's read-during-write output, which is don't-care.
- A write with `d_be`=0 still performs a full access and is acked; no bytes change.
- Requests are sampled only in IDLE. A `req` still high in RESP is not a new request. It is taken as a new request only if it is still high in the following IDLE cycle.
- If a requester drops `req` after the grant, the latched transaction still completes and is acked.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = DATA.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `i_ack`=`d_ack`=0, `i_rdata`=`d_rdata`=0.
- Latency: request sampled in cycle 0 → `mem_en` high in cycle 1 → ack and data in cycle 2.
- Maximum throughput is one access per 3 cycles.
- Acks are decoded from registered state and a registered grant flag. rdata is `mem_rdata` gated by the ack.
- Reset in any state: IDLE on the next edge, with no ack.
  - A write strobed in ACCESS still commits to RAM at the edge where reset is sampled; the RAM itself is not reset.
  - Reset sampled in the IDLE cycle that would grant suppresses the access entirely.
- `req` asserted in the same cycle reset is released is sampled on the first post-reset edge.

## Test plan
- Fetch read: RAM[0x010]=0xDEADBEEF; `i_req`=1, `i_addr`=0x010 at cycle 0 → `mem_en`=1, `mem_addr`=0x010 at cycle 1; `i_ack`=1, `i_rdata`=0xDEADBEEF at cycle 2 only; `d_ack` stays 0.
- Byte write then read: `d_we`=1, `d_be`=4'b0011, `d_addr`=0x020, `d_wdata`=0x12345678 onto RAM[0x020]=0xAAAAAAAA → `d_ack` at cycle 2; a following data read returns 0xAAAA5678.
- Contention: `i_req` and `d_req` both high from reset release → grants alternate fetch, data, fetch, data; each port is acked every 6 cycles; never two consecutive grants to one port.
- Held req: `d_req` held through RESP and IDLE → no ack in the IDLE cycle; a second access is granted on the following edge, and exactly one ack is issued per 3 cycles.
- Reset mid-operation: assert `reset` during RESP of a fetch → `i_ack` is 0 next cycle; all outputs return to reset values; first simultaneous contest after reset goes to fetch.
- Dropped req: `i_req` pulsed for one cycle only → access still completes; `i_ack`=1 at cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between the
// instruction-fetch port and the load/store port. One transaction is
// latched at a time: IDLE grants, ACCESS strobes the RAM, RESP acks.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ack,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } port_e;

  state_e                state_q, state_d;
  port_e                 last_grant_q, last_grant_d;
  port_e                 grant_q, grant_d;
  port_e                 win_port;
  logic                  mem_en_q, mem_en_d;
  logic [BE_WIDTH-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // State register and RAM-side transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_DATA;
      grant_q      <= PORT_FETCH;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state: requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_req || d_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Winner selection and latching of the winner's transaction into mem_*
  always_comb begin
    if (i_req && d_req) begin
      win_port = (last_grant_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    end else if (d_req) begin
      win_port = PORT_DATA;
    end else begin
      win_port = PORT_FETCH;
    end

    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d      = win_port;
          last_grant_d = win_port;
          mem_en_d     = 1'b1;
          if (win_port == PORT_DATA) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we ? d_be : '0;
          end else begin
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_we_d    = '0;
          end
        end
      end
      S_ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = '0;
      end
      default: ;
    endcase
  end

  // Acks decoded from registered state and grant; read data gated by ack
  always_comb begin
    i_ack   = (state_q == S_RESP) && (grant_q == PORT_FETCH);
    d_ack   = (state_q == S_RESP) && (grant_q == PORT_DATA);
    i_rdata = i_ack ? mem_rdata : '0;
    d_rdata = d_ack ? mem_rdata : '0;
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected ack
// (port + read data) into a queue, a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [13:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] ram [0:16383];

  mem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM with byte write enables
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: rdata gating, single-ack, and scoreboard pop on every ack
  always @(negedge clk) begin
    exp_t e;
    if (!i_ack) check("i_rdata_gated", i_rdata, 32'h0);
    if (!d_ack) check("d_rdata_gated", d_rdata, 32'h0);
    check1("single_ack", i_ack & d_ack, 1'b0);
    if (i_ack || d_ack) begin
      check1("ack_expected", sb.size() == 0, 1'b0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check1("ack_port", d_ack, e.is_d);
        if (e.chk) check("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
      end
    end
  end

  // One isolated access starting in an IDLE cycle; returns in the next IDLE cycle
  task automatic do_access(input logic is_d, input logic we, input logic [3:0] be,
                           input logic [13:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic chk, input logic drop);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    sb.push_back(exp_t'{is_d, chk, exp_rd});
    tick();
    if (drop) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    check1("acc_mem_en", mem_en, 1'b1);
    check("acc_mem_addr", {18'h0, mem_addr}, {18'h0, addr});
    check("acc_mem_we", {28'h0, mem_we}, {28'h0, (is_d && we) ? be : 4'h0});
    if (is_d && we) check("acc_mem_wdata", mem_wdata, wdata);
    check1("acc_no_early_ack", i_ack | d_ack, 1'b0);
    tick();
    check1("resp_ack", is_d ? d_ack : i_ack, 1'b1);
    check1("resp_other_ack", is_d ? i_ack : d_ack, 1'b0);
    check1("resp_mem_en", mem_en, 1'b0);
    check("resp_mem_we", {28'h0, mem_we}, 32'h0);
    tick();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check1("idle_no_ack", i_ack | d_ack, 1'b0);
  endtask

  // Both ports request continuously for two rounds; fetch must win first
  task automatic contend();
    i_req = 1'b1; i_addr = 14'h040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h050;
    sb.push_back(exp_t'{1'b0, 1'b1, 32'h40404040});
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h50505050});
    sb.push_back(exp_t'{1'b0, 1'b1, 32'h40404040});
    sb.push_back(exp_t'{1'b1, 1'b1, 32'h50505050});
    for (int k = 1; k <= 11; k++) begin
      tick();
      check1("contend_i_ack", i_ack, (k % 6) == 2);
      check1("contend_d_ack", d_ack, (k % 6) == 5);
    end
    tick();
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    ram[14'h010] <= 32'hDEADBEEF;
    ram[14'h011] <= 32'h0BADF00D;
    ram[14'h020] <= 32'hAAAAAAAA;
    ram[14'h030] <= 32'h30303030;
    ram[14'h040] <= 32'h40404040;
    ram[14'h050] <= 32'h50505050;
    tick();
    tick();

    // Reset values
    check1("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", {28'h0, mem_we}, 32'h0);
    check("rst_mem_addr", {18'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check1("rst_i_ack", i_ack, 1'b0);
    check1("rst_d_ack", d_ack, 1'b0);

    // Request present while reset is held: no access may start
    i_req = 1'b1; i_addr = 14'h010;
    tick();
    check1("rst_suppress_en", mem_en, 1'b0);
    tick();
    check1("rst_suppress_en2", mem_en, 1'b0);
    check1("rst_suppress_ack", i_ack, 1'b0);
    reset = 1'b0;

    // Fetch read, request raised in the reset-release cycle
    do_access(1'b0, 1'b0, 4'h0, 14'h010, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // Byte write, read back, zero-byte-enable write, read back
    do_access(1'b1, 1'b1, 4'b0011, 14'h020, 32'h12345678, 32'h0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 4'h0, 14'h020, 32'h0, 32'hAAAA5678, 1'b1, 1'b0);
    do_access(1'b1, 1'b1, 4'b0000, 14'h020, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 4'h0, 14'h020, 32'h0, 32'hAAAA5678, 1'b1, 1'b0);

    // Fetch request pulsed for a single cycle still completes
    do_access(1'b0, 1'b0, 4'h0, 14'h011, 32'h0, 32'h0BADF00D, 1'b1, 1'b1);

    // Data request held: one ack every 3 cycles, none in IDLE
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h030;
    for (int n = 0; n < 3; n++) sb.push_back(exp_t'{1'b1, 1'b1, 32'h30303030});
    for (int k = 1; k <= 8; k++) begin
      tick();
      check1("held_d_ack", d_ack, (k % 3) == 2);
    end
    tick();
    d_req = 1'b0;
    check1("held_idle_ack", d_ack, 1'b0);
    tick();
    check1("held_no_4th", mem_en, 1'b0);

    // Contention with last_grant at DATA
    contend();

    // Reset during RESP of a fetch, then contest right after release
    i_req = 1'b1; i_addr = 14'h010;
    sb.push_back(exp_t'{1'b0, 1'b1, 32'hDEADBEEF});
    tick();
    tick();
    check1("rstmid_resp_ack", i_ack, 1'b1);
    reset = 1'b1; i_req = 1'b0;
    tick();
    check1("rstmid_i_ack", i_ack, 1'b0);
    check1("rstmid_d_ack", d_ack, 1'b0);
    check1("rstmid_mem_en", mem_en, 1'b0);
    check("rstmid_mem_we", {28'h0, mem_we}, 32'h0);
    check("rstmid_mem_addr", {18'h0, mem_addr}, 32'h0);
    check("rstmid_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    contend();

    tick();
    tick();
    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
